// File: rtl/usb_rx_packet_buffer_if.sv
// Receive-side bus of the USB packet buffer. It carries the byte stream from the
// ULPI protocol FSM, the consumer read port and the packet status flags.
interface usb_rx_packet_buffer_if #(
    parameter int LEN_W = 10
);
    logic             new_byte;
    logic [7:0]       byte_in;
    logic             rx_active;
    logic             rd_en;
    logic             pkt_ready;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             overflow;
    logic             pkt_dropped;
    logic             busy;

    // The buffer is the slave: it takes bytes and read requests, and returns status and data.
    modport slave (
        input  new_byte, byte_in, rx_active, rd_en,
        output pkt_ready, pkt_len, rd_data, rd_valid, overflow, pkt_dropped, busy
    );

    // The master is the receive path and consumer side, which drives bytes and read requests.
    modport master (
        output new_byte, byte_in, rx_active, rd_en,
        input  pkt_ready, pkt_len, rd_data, rd_valid, overflow, pkt_dropped, busy
    );
endinterface

// File: rtl/usb_rx_packet_buffer.sv
// USB receive packet buffer. It captures one packet into a byte RAM while
// rx_active is high, then holds that packet for byte-serial readout. A packet
// that arrives while the buffer still holds one is discarded.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | empty, waiting for rx_active
// COLLECT | storing incoming bytes (excess bytes set overflow)
// READY   | packet held, consumer reading
// DROP    | new receive while occupied: ignore its bytes, keep held packet
module usb_rx_packet_buffer #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input logic                 clk,
    input logic                 rst,
    usb_rx_packet_buffer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_READY, S_DROP} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             dropped_q, dropped_d;

    logic [7:0]       mem_q [DEPTH];
    logic             mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    logic             wr_room;
    logic             rd_ok;
    logic [LEN_W-1:0] rd_ptr_inc;
    logic [LEN_W-1:0] rd_ptr_next;
    logic [LEN_W-1:0] collect_final;

    // The write is never issued past DEPTH, so addresses never wrap.
    assign wr_room       = (wr_cnt_q < DEPTH_L);
    assign collect_final = (bus.new_byte && wr_room) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    assign rd_ok         = bus.rd_en && (rd_ptr_q < pkt_len_q)
                           && (state_q == S_READY || state_q == S_DROP);
    assign rd_ptr_inc    = rd_ptr_q + 1'b1;
    assign rd_ptr_next   = rd_ok ? rd_ptr_inc : rd_ptr_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. A new receive while READY takes priority over finishing the readout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.rx_active) state_d = S_COLLECT;
            S_COLLECT: if (!bus.rx_active) state_d = (collect_final == '0) ? S_IDLE : S_READY;
            S_READY: begin
                if (bus.rx_active)                        state_d = S_DROP;
                else if (rd_ok && rd_ptr_inc == pkt_len_q) state_d = S_IDLE;
            end
            S_DROP:    if (!bus.rx_active) state_d = (rd_ptr_next != pkt_len_q) ? S_READY : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs. pkt_ready stays high in DROP only while unread bytes remain.
    always_comb begin
        bus.busy      = (state_q == S_COLLECT) || (state_q == S_READY);
        bus.pkt_ready = (state_q == S_READY)
                        || ((state_q == S_DROP) && (rd_ptr_q != pkt_len_q));
    end

    // Datapath next values: counters, length latch, sticky overflow and the read port.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_len_d  = pkt_len_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        dropped_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_cnt_q[ADDR_W-1:0];
        case (state_q)
            S_IDLE: begin
                wr_cnt_d  = '0;
                rd_ptr_d  = '0;
                pkt_len_d = '0;
                if (bus.rx_active) begin
                    overflow_d = 1'b0;
                    if (bus.new_byte) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_cnt_d  = LEN_W'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (bus.new_byte) begin
                    if (wr_room) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (!bus.rx_active) pkt_len_d = collect_final;
            end
            S_READY, S_DROP: begin
                if (rd_ok) begin
                    rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_inc;
                end
                if (state_q == S_READY && bus.rx_active) dropped_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers. A reset discards any packet in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_len_q  <= pkt_len_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            dropped_q  <= dropped_d;
        end
    end

    // Byte RAM write port. The contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= bus.byte_in;
    end

    assign bus.pkt_len     = pkt_len_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.pkt_dropped = dropped_q;
endmodule

// File: doc/usb_rx_packet_buffer.md
Name: usb_rx_packet_buffer

Overview:
- Sits directly downstream of the ULPI protocol state machine.
- Captures each byte that state machine passes through (its new_byte strobe plus byte bus) into an internal byte RAM.
- Closes the packet when the PHY releases the bus, then presents length and a byte-serial read port to the packet consumer.
- Handles overflow, empty packets and packets that arrive while the buffer is still occupied.

Parameters:
DEPTH, 512, packet buffer capacity in bytes (power of two)
ADDR_W, 9, log2(DEPTH)
LEN_W, 10, ADDR_W+1; width of byte count (holds 0..DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
new_byte  in  1  single-cycle strobe: byte_in valid this cycle
byte_in  in  8  received data byte from protocol state machine
rx_active  in  1  high while a receive is in progress (PHY dir)
rd_en  in  1  consumer read request, one byte per asserted cycle
pkt_ready  out  1  complete packet held, readable
pkt_len  out  LEN_W  byte count of held packet
rd_data  out  8  read byte, registered
rd_valid  out  1  rd_data valid this cycle
overflow  out  1  sticky: current/last packet exceeded DEPTH
pkt_dropped  out  1  one-cycle pulse: a packet arrived while READY and was discarded
busy  out  1  high in COLLECT or READY

Behaviour:
- Reset: state IDLE; wr_cnt=0, rd_ptr=0; all outputs 0. RAM contents are don't-care.
- States: IDLE, COLLECT, READY, DROP.
- IDLE:
  - rx_active=1 -> COLLECT.
  - If new_byte is also high that cycle, write it at address 0 with wr_cnt=1; otherwise wr_cnt=0.
  - overflow clears on entry to COLLECT.
- COLLECT:
  - new_byte with wr_cnt<DEPTH: mem[wr_cnt]<=byte_in, wr_cnt++.
  - new_byte with wr_cnt==DEPTH: byte discarded, overflow<=1.
  - rx_active=0: the same-cycle new_byte is still accepted. Next state is IDLE if the final count is 0 (empty packet, no pkt_ready). Otherwise next state is READY with pkt_len<=final count, saturated at DEPTH.
- READY:
  - pkt_ready=1 and pkt_len stable.
  - rd_en with rd_ptr<pkt_len: rd_data<=mem[rd_ptr] and rd_valid=1 on the next cycle; rd_ptr++.
  - rd_en with rd_ptr==pkt_len: ignored, rd_valid stays 0.
  - When the read of the last byte is issued (rd_ptr becomes pkt_len), next state is IDLE. pkt_ready drops that same next cycle; the final rd_valid still occurs in that cycle. rd_ptr, wr_cnt and pkt_len are cleared in IDLE.
  - rx_active=1 while READY: next state DROP, pkt_dropped pulses for one cycle. The held packet is untouched and remains readable (reads in DROP behave as in READY).
- DROP:
  - Ignores new_byte.
  - Leaves when rx_active=0: to READY if unread bytes remain, else IDLE.
  - If the last byte is read while in DROP, return to DROP-equivalent discard until rx_active=0, then go IDLE. Never capture a partial packet.
- Width rules: wr_cnt and rd_ptr are LEN_W bits; RAM is addressed with the low ADDR_W bits. No wrap-around writes ever occur.
- rd_valid is exactly one cycle per accepted rd_en. Read latency is 1 cycle.
- Async rst mid-operation: immediate return to IDLE, all outputs 0, packet lost.
- RAM: a single-port read and single-port write on clk; no read-during-write hazard, because reads occur only in READY/DROP and writes only in IDLE/COLLECT.

Test Plan:
- 4-byte packet: rx_active=1, bytes 0xA1,0xB2,0xC3,0xD4 on new_byte, then rx_active=0 -> pkt_ready=1 next cycle with pkt_len=4. Four rd_en pulses -> rd_valid with rd_data A1,B2,C3,D4 each one cycle after its rd_en; pkt_ready=0 the cycle the last rd_valid appears; busy=0 after.
- Empty packet: rx_active high 10 cycles with no new_byte, then low -> pkt_ready never asserts, return to IDLE, overflow=0.
- Overflow: 515 bytes (value = index mod 256) -> overflow=1 and pkt_len=512. Reading all 512 returns 0x00..0xFF twice; overflow stays 1 until the next rx_active rise.
- Last-byte edge: new_byte=1 (0x5E) in the same cycle rx_active falls after 2 prior bytes -> pkt_len=3, third byte read = 0x5E.
- Busy buffer: packet of 2 held unread, new rx_active burst of 3 bytes -> pkt_dropped one-cycle pulse, pkt_len stays 2, reads return the original 2 bytes, then IDLE.
- Reset mid-COLLECT after 5 bytes: assert rst -> all outputs 0 immediately. The next clean 1-byte packet reports pkt_len=1.
